// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared types, constants and helpers for the Reaper next-PC sequencer.
//   Contents: sequencer state enum, next-PC source enum, clog2 helper, default widths.
package pc_seq_pkg;
   localparam int PC_W_DEF        = 13;
   localparam int STACK_DEPTH_DEF = 16;
   typedef enum logic [1:0] {ST_RUN, ST_HALTED, ST_FAULT} seq_state_t;
   typedef enum logic [2:0] {SRC_SEQ, SRC_REG, SRC_IMM, SRC_CALL, SRC_RET} pc_src_t;
   function automatic int clog2(input int v);
      int r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction
endpackage

// File: rtl/ret_addr_stack.sv
// ret_addr_stack: return-address LIFO with push, pop and same-cycle swap (replace top).
//   Ports: clk, rst_n (async active-low), push, pop, din -> top, count, full, empty.
//   PC_SEQ_CIRCULAR_STACK_EN: a push on a full stack overwrites the oldest entry.
//   Without it a push on a full stack is dropped (the caller treats it as a fault).
//   Reset clears pointer and count only; entry contents are left as they are.
module ret_addr_stack
   import pc_seq_pkg::*;
#(
   parameter int PC_W  = PC_W_DEF,
   parameter int DEPTH = STACK_DEPTH_DEF,
   localparam int AW   = clog2(DEPTH),
   localparam int CW   = clog2(DEPTH + 1)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            push,
   input  logic            pop,
   input  logic [PC_W-1:0] din,
   output logic [PC_W-1:0] top,
   output logic [CW-1:0]   count,
   output logic            full,
   output logic            empty
);
`ifdef PC_SEQ_CIRCULAR_STACK_EN
   localparam bit CIRC = 1'b1;
`else
   localparam bit CIRC = 1'b0;
`endif
   logic [PC_W-1:0] mem [DEPTH];
   logic [AW-1:0]   sp, sp_inc, sp_dec;
   logic            do_push, do_pop, do_swap;
   // sp is the next free slot; in a full circular stack that slot holds the oldest entry
   assign sp_inc  = sp == AW'(DEPTH - 1) ? '0 : sp + 1'b1;
   assign sp_dec  = sp == '0 ? AW'(DEPTH - 1) : sp - 1'b1;
   assign top     = mem[sp_dec];
   assign full    = count == CW'(DEPTH);
   assign empty   = count == '0;
   assign do_push = push && !pop && (CIRC || !full);
   assign do_pop  = pop && !push && !empty;
   assign do_swap = push && pop && !empty;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         sp    <= '0;
         count <= '0;
      end else if (do_push) begin
         sp    <= sp_inc;
         count <= full ? count : count + 1'b1;
      end else if (do_pop) begin
         sp    <= sp_dec;
         count <= count - 1'b1;
      end
   always_ff @(posedge clk)
      if (do_swap) mem[sp_dec] <= din;
      else if (do_push) mem[sp] <= din;
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: Reaper next-PC sequencer with PC register, return stack and RUN/HALTED/FAULT FSM.
//   Inputs : Sys_Clock, Raw_Reset_I (async active-low), Step_En, Stall, Halt, Resume, Branch,
//            Cond_True, Jump_R, Reg_Target, Jump_I, Imm_Target, Call, Ret.
//   Outputs: PC, Halted, Fault, Err_Overflow, Err_Underflow (sticky), Stack_Count.
//   PC_SEQ_CIRCULAR_STACK_EN: stack overflow is a warning and the call completes;
//   otherwise overflow drops the call and faults.
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter int              PC_W         = PC_W_DEF,
   parameter int              STACK_DEPTH  = STACK_DEPTH_DEF,
   parameter logic [PC_W-1:0] RESET_VECTOR = '0,
   localparam int             CW           = clog2(STACK_DEPTH + 1)
) (
   input  logic            Sys_Clock,
   input  logic            Raw_Reset_I,
   input  logic            Step_En,
   input  logic            Stall,
   input  logic            Halt,
   input  logic            Resume,
   input  logic            Branch,
   input  logic            Cond_True,
   input  logic            Jump_R,
   input  logic [PC_W-1:0] Reg_Target,
   input  logic            Jump_I,
   input  logic [PC_W-1:0] Imm_Target,
   input  logic            Call,
   input  logic            Ret,
   output logic [PC_W-1:0] PC,
   output logic            Halted,
   output logic            Fault,
   output logic            Err_Overflow,
   output logic            Err_Underflow,
   output logic [CW-1:0]   Stack_Count
);
   seq_state_t      state_q, state_d;
   pc_src_t         src;
   logic [PC_W-1:0] pc_q, pc_d, pc_inc, top;
   logic            step, act, uf, ov, ov_fault, push, pop, full, empty, err_ov_q, err_uf_q;
   // a halt step only advances the PC, so every control action below is gated by act
   assign step   = Step_En && !Stall && state_q == ST_RUN;
   assign act    = step && !Halt;
   assign pc_inc = pc_q + 1'b1;
   assign uf     = act && Ret && empty;
   assign ov     = act && Call && !Ret && full;
`ifdef PC_SEQ_CIRCULAR_STACK_EN
   assign ov_fault = 1'b0;
`else
   assign ov_fault = ov;
`endif
   // Call together with Ret drives push and pop at once, which the stack treats as a swap
   assign push = act && Call && !uf && !ov_fault;
   assign pop  = act && Ret && !uf;
   always_comb begin
      src     = Ret ? SRC_RET : Call ? SRC_CALL : Jump_I ? SRC_IMM :
                ((Branch && Cond_True) || Jump_R) ? SRC_REG : SRC_SEQ;
      pc_d    = pc_q;
      state_d = state_q;
      if (step)
         pc_d = Halt ? pc_inc : (uf || ov_fault) ? pc_q : src == SRC_RET ? top :
                (src == SRC_CALL || src == SRC_IMM) ? Imm_Target :
                src == SRC_REG ? Reg_Target : pc_inc;
      if (state_q == ST_RUN)
         state_d = (step && Halt) ? ST_HALTED : (uf || ov_fault) ? ST_FAULT : ST_RUN;
      else if (state_q == ST_HALTED)
         state_d = Resume ? ST_RUN : ST_HALTED;
   end
   always_ff @(posedge Sys_Clock or negedge Raw_Reset_I)
      if (!Raw_Reset_I) begin
         state_q  <= ST_RUN;
         pc_q     <= RESET_VECTOR;
         err_ov_q <= 1'b0;
         err_uf_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         err_ov_q <= err_ov_q || ov;
         err_uf_q <= err_uf_q || uf;
      end
   ret_addr_stack #(.PC_W(PC_W), .DEPTH(STACK_DEPTH)) u_stack (
      .clk  (Sys_Clock),
      .rst_n(Raw_Reset_I),
      .push (push),
      .pop  (pop),
      .din  (pc_inc),
      .top  (top),
      .count(Stack_Count),
      .full (full),
      .empty(empty)
   );
   assign PC            = pc_q;
   assign Halted        = state_q == ST_HALTED;
   assign Fault         = state_q == ST_FAULT;
   assign Err_Overflow  = err_ov_q;
   assign Err_Underflow = err_uf_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed and randomized checks of pc_sequencer against a queue-based model.
module tb_pc_sequencer;
   import pc_seq_pkg::*;
   localparam int PC_W = 13;
   localparam int DEPTH = 4;
   localparam int CW = clog2(DEPTH + 1);
   localparam int MASK = (1 << PC_W) - 1;
   localparam int M_RUN = 0, M_HALTED = 1, M_FAULT = 2;
   logic clk = 0, rst_n = 0;
   logic step_en, stall, halt, resume, branch, cond_true, jump_r, jump_i, call, ret;
   logic [PC_W-1:0] reg_target, imm_target, pc;
   logic halted, fault, err_ov, err_uf;
   logic [CW-1:0] stack_count;
   int n_chk = 0, n_pass = 0;
   int m_pc, m_state;
   bit m_ov, m_uf;
   int stk[$];
   always #5 clk = ~clk;
   pc_sequencer #(.PC_W(PC_W), .STACK_DEPTH(DEPTH), .RESET_VECTOR('0)) dut (
      .Sys_Clock(clk), .Raw_Reset_I(rst_n), .Step_En(step_en), .Stall(stall), .Halt(halt),
      .Resume(resume), .Branch(branch), .Cond_True(cond_true), .Jump_R(jump_r),
      .Reg_Target(reg_target), .Jump_I(jump_i), .Imm_Target(imm_target), .Call(call), .Ret(ret),
      .PC(pc), .Halted(halted), .Fault(fault), .Err_Overflow(err_ov), .Err_Underflow(err_uf),
      .Stack_Count(stack_count)
   );
   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask
   task automatic clear();
      {step_en, stall, halt, resume, branch, cond_true, jump_r, jump_i, call, ret} = '0;
      reg_target = '0;
      imm_target = '0;
   endtask
   task automatic model_reset();
      m_pc = 0; m_state = M_RUN; m_ov = 0; m_uf = 0;
      stk.delete();
   endtask
   task automatic model_edge();
      int inc = (m_pc + 1) & MASK;
      int t;
      if (m_state == M_HALTED) begin
         if (resume) m_state = M_RUN;
         return;
      end
      if (m_state == M_FAULT || !step_en || stall) return;
      if (halt) begin
         m_pc = inc; m_state = M_HALTED;
         return;
      end
      if (ret) begin
         if (stk.size() == 0) begin
            m_uf = 1; m_state = M_FAULT;
            return;
         end
         t = stk.pop_back();
         if (call) stk.push_back(inc);
         m_pc = t;
         return;
      end
      if (call) begin
         if (stk.size() == DEPTH) begin
            m_ov = 1;
`ifdef PC_SEQ_CIRCULAR_STACK_EN
            void'(stk.pop_front());
            stk.push_back(inc);
            m_pc = int'(imm_target);
`else
            m_state = M_FAULT;
`endif
            return;
         end
         stk.push_back(inc);
         m_pc = int'(imm_target);
         return;
      end
      if (jump_i) m_pc = int'(imm_target);
      else if ((branch && cond_true) || jump_r) m_pc = int'(reg_target);
      else m_pc = inc;
   endtask
   task automatic check_all();
      chk("pc", int'(pc), m_pc);
      chk("halted", int'(halted), int'(m_state == M_HALTED));
      chk("fault", int'(fault), int'(m_state == M_FAULT));
      chk("err_ov", int'(err_ov), int'(m_ov));
      chk("err_uf", int'(err_uf), int'(m_uf));
      chk("count", int'(stack_count), stk.size());
   endtask
   task automatic cycle();
      @(posedge clk);
      if (rst_n) model_edge();
      #1 check_all();
      clear();
   endtask
   task automatic do_reset();
      @(negedge clk);
      rst_n = 0;
      #1 model_reset();
      check_all();
      @(negedge clk);
      rst_n = 1;
   endtask
   task automatic jmp(input int a);
      step_en = 1; jump_i = 1; imm_target = PC_W'(a);
      cycle();
   endtask
   task automatic do_call(input int a);
      step_en = 1; call = 1; imm_target = PC_W'(a);
      cycle();
   endtask
   task automatic do_ret();
      step_en = 1; ret = 1;
      cycle();
   endtask
   initial begin
      clear();
      do_reset();
      chk("reset_pc", int'(pc), 0);
      for (int i = 1; i <= 3; i++) begin
         step_en = 1; cycle();
         chk("plain_step", int'(pc), i);
      end
      step_en = 1; stall = 1; cycle();
      chk("stall_hold", int'(pc), 3);
      jmp(13'h1fff);
      step_en = 1; cycle();
      chk("pc_wrap", int'(pc), 0);
      jmp(13'h1fff);
      do_call(13'h40);
      chk("call_wrap_pc", int'(pc), 13'h40);
      do_ret();
      chk("ret_wrap_addr", int'(pc), 0);
      jmp(13'h10);
      do_call(13'h80);
      chk("call_count", int'(stack_count), 1);
      jmp(13'h85);
      do_ret();
      chk("ret_pc", int'(pc), 13'h11);
      chk("ret_count", int'(stack_count), 0);
      do_ret();
      chk("uf_flag", int'(err_uf), 1);
      chk("uf_fault", int'(fault), 1);
      chk("uf_pc", int'(pc), 13'h11);
      for (int i = 0; i < 3; i++) begin
         step_en = 1; call = i[0]; imm_target = 13'h55; cycle();
      end
      chk("fault_frozen", int'(pc), 13'h11);
      do_reset();
      for (int i = 1; i <= 5; i++) do_call(i * 13'h100);
      chk("ov_count", int'(stack_count), 4);
      chk("ov_flag", int'(err_ov), 1);
`ifdef PC_SEQ_CIRCULAR_STACK_EN
      chk("ov_pc", int'(pc), 13'h500);
      for (int i = 4; i >= 1; i--) begin
         do_ret();
         chk("circ_ret", int'(pc), i * 13'h100 + 1);
      end
      do_ret();
      chk("circ_uf_fault", int'(fault), 1);
`else
      chk("ov_fault", int'(fault), 1);
      chk("ov_pc_held", int'(pc), 13'h400);
`endif
      do_reset();
      jmp(13'h20);
      step_en = 1; halt = 1; cycle();
      chk("halt_pc", int'(pc), 13'h21);
      chk("halt_flag", int'(halted), 1);
      for (int i = 0; i < 5; i++) begin
         step_en = 1; branch = 1; cond_true = 1; reg_target = 13'h300; cycle();
      end
      chk("halt_frozen", int'(pc), 13'h21);
      resume = 1; cycle();
      chk("resume_run", int'(halted), 0);
      step_en = 1; cycle();
      chk("after_resume", int'(pc), 13'h22);
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(99) < 3) do_reset();
         else begin
            step_en = $urandom_range(99) < 75;
            stall = $urandom_range(99) < 15;
            halt = $urandom_range(99) < 5;
            resume = $urandom_range(99) < 30;
            branch = $urandom_range(99) < 20;
            cond_true = $urandom_range(1) == 1;
            jump_r = $urandom_range(99) < 10;
            jump_i = $urandom_range(99) < 10;
            call = $urandom_range(99) < 20;
            ret = $urandom_range(99) < 15;
            reg_target = PC_W'($urandom);
            imm_target = $urandom_range(3) == 0 ? PC_W'(MASK) : PC_W'($urandom);
            cycle();
         end
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
